shift_unit_seq: RTL and testbench

Iterative, parametrised shift unit for the ALU datapath. It supports logical, arithmetic and rotate shifts by a run-time shift amount, with operand select between A and B. Operands are accepted over a ready/start handshake, and the unit shifts one bit per enabled cycle. It returns a registered result with done, carry and zero flags.

---
 rtl/shift_unit_seq.sv | 150 +++++++++++++++
 tb/tb_shift_unit_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: iterative shift unit for the ALU datapath. One bit is shifted
// per enabled cycle; the result and flags are registered on entry to DONE.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   A, B, SRC_SEL     operands and operand select (0 = A, 1 = B)
//   SHAMT             shift amount (any value legal, no wrap)
//   ALU_FUNC          000 LSR, 001 LSL, 010 ASR, 011 ROR, 100 ROL, others pass-through
//   EN                advance enable; the unit freezes when low
//   START, IN_READY   request / ready handshake
//   Shift_OUT         result register
//   Shift_Flag        done strobe (high while in DONE)
//   Carry_Flag        last bit shifted out
//   Zero_Flag         Shift_OUT == 0
module shift_unit_seq #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SHAMT_WIDTH = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic                   SRC_SEL,
    input  logic [SHAMT_WIDTH-1:0] SHAMT,
    input  logic [2:0]             ALU_FUNC,
    input  logic                   EN,
    input  logic                   START,
    output logic                   IN_READY,
    output logic [DATA_WIDTH-1:0]  Shift_OUT,
    output logic                   Shift_Flag,
    output logic                   Carry_Flag,
    output logic                   Zero_Flag
);

    localparam logic [2:0] FUNC_LSR = 3'b000;
    localparam logic [2:0] FUNC_LSL = 3'b001;
    localparam logic [2:0] FUNC_ASR = 3'b010;
    localparam logic [2:0] FUNC_ROR = 3'b011;
    localparam logic [2:0] FUNC_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [DATA_WIDTH-1:0]  r_work;
    logic [SHAMT_WIDTH-1:0] r_cnt;
    logic [2:0]             r_mode;
    logic [DATA_WIDTH-1:0]  r_shift_out;
    logic                   r_carry_flag;
    logic                   r_zero_flag;

    logic [DATA_WIDTH-1:0]  w_operand;
    logic [DATA_WIDTH-1:0]  w_shifted;
    logic                   w_bit_out;
    logic                   w_bypass;

    assign w_operand = SRC_SEL ? B : A;

    // Zero amount and reserved modes skip SHIFT and return the operand as-is.
    assign w_bypass = (SHAMT == '0) || (ALU_FUNC > FUNC_ROL);

    // One-bit step of the working register for the captured mode.
    always_comb begin
        w_shifted = r_work;
        w_bit_out = 1'b0;
        case (r_mode)
            FUNC_LSR: begin
                w_shifted = {1'b0, r_work[DATA_WIDTH-1:1]};
                w_bit_out = r_work[0];
            end
            FUNC_LSL: begin
                w_shifted = {r_work[DATA_WIDTH-2:0], 1'b0};
                w_bit_out = r_work[DATA_WIDTH-1];
            end
            FUNC_ASR: begin
                w_shifted = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
                w_bit_out = r_work[0];
            end
            FUNC_ROR: begin
                w_shifted = {r_work[0], r_work[DATA_WIDTH-1:1]};
                w_bit_out = r_work[0];
            end
            FUNC_ROL: begin
                w_shifted = {r_work[DATA_WIDTH-2:0], r_work[DATA_WIDTH-1]};
                w_bit_out = r_work[DATA_WIDTH-1];
            end
            default: begin
                w_shifted = r_work;
                w_bit_out = 1'b0;
            end
        endcase
    end

    // Control FSM and datapath registers; everything holds while EN is low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_work       <= '0;
            r_cnt        <= '0;
            r_mode       <= FUNC_LSR;
            r_shift_out  <= '0;
            r_carry_flag <= 1'b0;
            r_zero_flag  <= 1'b0;
        end else if (EN) begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        r_work <= w_operand;
                        r_mode <= ALU_FUNC;
                        r_cnt  <= SHAMT;
                        if (w_bypass) begin
                            r_state      <= ST_DONE;
                            r_shift_out  <= w_operand;
                            r_carry_flag <= 1'b0;
                            r_zero_flag  <= (w_operand == '0);
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
                    // Final step: publish result and flags together.
                    if (r_cnt == SHAMT_WIDTH'(1)) begin
                        r_state      <= ST_DONE;
                        r_shift_out  <= w_shifted;
                        r_carry_flag <= w_bit_out;
                        r_zero_flag  <= (w_shifted == '0);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign IN_READY   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign Shift_Flag = (r_state == ST_DONE);
    assign Shift_OUT  = r_shift_out;
    assign Carry_Flag = r_carry_flag;
    assign Zero_Flag  = r_zero_flag;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: scoreboard bench for shift_unit_seq. The driver pushes the
// expected result of every accepted request; a monitor pops and compares each
// time the unit presents a completed result.
module tb_shift_unit_seq;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          SRC_SEL;
    logic [SW-1:0] SHAMT;
    logic [2:0]    ALU_FUNC;
    logic          EN;
    logic          START;
    logic          IN_READY;
    logic [DW-1:0] Shift_OUT;
    logic          Shift_Flag;
    logic          Carry_Flag;
    logic          Zero_Flag;

    shift_unit_seq #(
        .DATA_WIDTH (DW),
        .SHAMT_WIDTH(SW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .SRC_SEL   (SRC_SEL),
        .SHAMT     (SHAMT),
        .ALU_FUNC  (ALU_FUNC),
        .EN        (EN),
        .START     (START),
        .IN_READY  (IN_READY),
        .Shift_OUT (Shift_OUT),
        .Shift_Flag(Shift_Flag),
        .Carry_Flag(Carry_Flag),
        .Zero_Flag (Zero_Flag)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] res;
        logic          cy;
        logic          zf;
        int            acc;   // edge index of the accept
        int            lat;   // EN=1 edges from accept to DONE entry
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   en_hist [0:65535];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: the whole shift computed at once from the mode's definition.
    function automatic exp_t model(input logic [DW-1:0] d, input int sh, input logic [2:0] f);
        exp_t e;
        int k;
        logic [2*DW-1:0] dbl;
        e.res = d;
        e.cy  = 1'b0;
        e.lat = 0;
        e.acc = 0;
        if (sh != 0 && f <= 3'd4) begin
            e.lat = sh;
            k   = sh % DW;
            dbl = {d, d};
            case (f)
                3'd0: begin
                    e.res = (sh >= DW) ? '0 : (d >> sh);
                    e.cy  = (sh <= DW) ? d[sh-1] : 1'b0;
                end
                3'd1: begin
                    e.res = (sh >= DW) ? '0 : (d << sh);
                    e.cy  = (sh <= DW) ? d[DW-sh] : 1'b0;
                end
                3'd2: begin
                    e.res = (sh >= DW) ? {DW{d[DW-1]}} : DW'($signed(d) >>> sh);
                    e.cy  = (sh <= DW) ? d[sh-1] : d[DW-1];
                end
                3'd3: begin
                    dbl   = dbl >> k;
                    e.res = dbl[DW-1:0];
                    e.cy  = e.res[DW-1];
                end
                default: begin
                    dbl   = dbl << k;
                    e.res = dbl[2*DW-1:DW];
                    e.cy  = e.res[0];
                end
            endcase
        end
        e.zf = (e.res == '0);
        return e;
    endfunction

    // One stimulus cycle; pushes an expectation when the request will be taken.
    task automatic drive(input bit st, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit sel, input int sh, input logic [2:0] f, input bit en);
        exp_t e;
        bit   rdy_exp;
        @(negedge CLK);
        A        = a;
        B        = b;
        SRC_SEL  = sel;
        SHAMT    = SW'(sh);
        ALU_FUNC = f;
        EN       = en;
        START    = st;
        rdy_exp  = (q.size() == 0);
        chk("in_ready", 32'(IN_READY), 32'(rdy_exp));
        if (st && en && rdy_exp) begin
            e     = model(sel ? b : a, sh, f);
            e.acc = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 64) begin
            drive(1'b0, DW'($urandom), DW'($urandom), 1'b0, 0, 3'd0, 1'b1);
            guard++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic run(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sel,
                       input int sh, input logic [2:0] f);
        drive(1'b1, a, b, sel, sh, f, 1'b1);
        drain();
        drive(1'b0, a, b, sel, sh, f, 1'b1);
    endtask

    // Monitor: a new result is a DONE entry, i.e. flag rising or DONE after an EN=1 edge.
    bit            prev_flag = 1'b0;
    logic [DW-1:0] last_out  = '0;
    logic          last_cy   = 1'b0;
    logic          last_z    = 1'b0;

    always @(posedge CLK) begin
        exp_t e;
        int   n;
        #1;
        en_hist[cyc] = EN;
        if (!RST) begin
            prev_flag = 1'b0;
            last_out  = '0;
            last_cy   = 1'b0;
            last_z    = 1'b0;
        end else begin
            if (Shift_Flag && (!prev_flag || en_hist[cyc])) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done: Shift_Flag=1 out=%0h with no request outstanding", Shift_OUT);
                end else begin
                    e = q.pop_front();
                    chk("result", 32'(Shift_OUT), 32'(e.res));
                    chk("carry", 32'(Carry_Flag), 32'(e.cy));
                    chk("zero", 32'(Zero_Flag), 32'(e.zf));
                    n = 0;
                    for (int i = e.acc + 1; i <= cyc; i++) n += int'(en_hist[i]);
                    chk("latency_en_edges", 32'(n), 32'(e.lat));
                    chk("done_edge_enabled", 32'(en_hist[cyc]), 32'd1);
                end
                last_out = Shift_OUT;
                last_cy  = Carry_Flag;
                last_z   = Zero_Flag;
            end else begin
                chk("output_hold", 32'({Shift_OUT, Carry_Flag, Zero_Flag}),
                    32'({last_out, last_cy, last_z}));
            end
            prev_flag = Shift_Flag;
        end
    end

    initial begin
        RST      = 1'b0;
        A        = '0;
        B        = '0;
        SRC_SEL  = 1'b0;
        SHAMT    = '0;
        ALU_FUNC = 3'd0;
        EN       = 1'b0;
        START    = 1'b0;
        #1;
        chk("reset_out", 32'(Shift_OUT), 32'd0);
        chk("reset_flags", 32'({Shift_Flag, Carry_Flag, Zero_Flag}), 32'd0);
        chk("reset_ready", 32'(IN_READY), 32'd1);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;

        // Directed cases
        run(8'hB4, 8'h00, 1'b0, 3, 3'd0);   // LSR -> 16, carry 1
        run(8'h00, 8'h90, 1'b1, 2, 3'd2);   // ASR B -> E4, carry 0
        run(8'h81, 8'h00, 1'b0, 1, 3'd4);   // ROL -> 03, carry 1
        run(8'h01, 8'h00, 1'b0, 9, 3'd3);   // ROR by 9 -> 80, carry 1
        run(8'h80, 8'h00, 1'b0, 1, 3'd1);   // LSL -> 00, zero 1, carry 1
        run(8'h5A, 8'h00, 1'b0, 0, 3'd0);   // SHAMT 0 bypass
        run(8'h3C, 8'h00, 1'b0, 5, 3'd7);   // reserved mode pass-through
        run(8'h00, 8'h00, 1'b0, 0, 3'd1);   // bypass of zero operand
        run(8'h80, 8'h00, 1'b0, 12, 3'd2);  // ASR beyond width -> FF
        run(8'hFF, 8'h00, 1'b0, 15, 3'd0);  // LSR beyond width -> 00

        // Stall: LSR by 4 with two EN=0 cycles mid-operation
        drive(1'b1, 8'hF0, 8'h00, 1'b0, 4, 3'd0, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 0, 3'd0, 1'b1);
        drive(1'b1, 8'h11, 8'h22, 1'b0, 0, 3'd0, 1'b0);
        drive(1'b1, 8'h11, 8'h22, 1'b0, 0, 3'd0, 1'b0);
        drain();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 0, 3'd0, 1'b1);

        // START with new operands during SHIFT must be ignored
        drive(1'b1, 8'hB4, 8'h00, 1'b0, 3, 3'd0, 1'b1);
        drive(1'b1, 8'hFF, 8'h01, 1'b1, 1, 3'd4, 1'b1);
        drive(1'b1, 8'hFF, 8'h01, 1'b1, 1, 3'd4, 1'b1);
        drain();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 0, 3'd0, 1'b1);

        // START held into DONE: back-to-back accept, then a bypass from DONE
        drive(1'b1, 8'h0F, 8'h00, 1'b0, 2, 3'd1, 1'b1);
        repeat (3) drive(1'b1, 8'hA5, 8'h00, 1'b0, 0, 3'd0, 1'b1);
        drive(1'b1, 8'h00, 8'hC3, 1'b1, 0, 3'd3, 1'b1);
        drain();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 0, 3'd0, 1'b1);

        // Asynchronous reset in the middle of a shift
        drive(1'b1, 8'hFF, 8'h00, 1'b0, 7, 3'd0, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 0, 3'd0, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 0, 3'd0, 1'b1);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("abort_out", 32'(Shift_OUT), 32'd0);
        chk("abort_flags", 32'({Shift_Flag, Carry_Flag, Zero_Flag}), 32'd0);
        chk("abort_ready", 32'(IN_READY), 32'd1);
        q.delete();
        @(posedge CLK);
        #2 RST = 1'b1;
        run(8'h02, 8'h00, 1'b0, 1, 3'd0);   // LSR -> 01 right after release

        // Randomized traffic with random EN and START noise while busy
        for (int i = 0; i < 600; i++) begin
            bit st;
            if (q.size() == 0) st = ($urandom_range(0, 4) != 0);
            else               st = 1'($urandom_range(0, 1));
            drive(st, DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0));
        end
        drain();
        repeat (2) drive(1'b0, 8'h00, 8'h00, 1'b0, 0, 3'd0, 1'b1);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
